// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// operand-forwarding codes and the canonical NOP instruction word.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } hz_state_e;

  localparam logic [1:0]  FWD_RF  = 2'b00;
  localparam logic [1:0]  FWD_MEM = 2'b01;
  localparam logic [1:0]  FWD_WB  = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A write to x0 is architecturally discarded, so it can never be a source.
  function automatic logic rd_hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
    return wr && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: the youngest in-flight producer (MEM) wins
// over WB; operands the instruction does not read always come from the regfile.
import hazard_pkg::*;

module fwd_sel (
  input  logic [4:0] rs,
  input  logic       use_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (use_rs) begin
      if (rd_hit(mem_reg_write, mem_rd, rs))
        fwd = FWD_MEM;
      else if (rd_hit(wb_reg_write, wb_rd, rs))
        fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: redirect flush, load-use stall, debug halt
// and operand forwarding. Define HAZARD_PERF_CNT_EN to build the saturating perf counters.
import hazard_pkg::*;

module pipe_hazard_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic            mem_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic            redirect_req,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            pc_sel,
  output logic [XLEN-1:0] pc_target,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e state_reg, state_next;
  logic      load_use;

  logic [4:0] rs_arr  [2];
  logic       use_arr [2];
  logic [1:0] fwd_arr [2];

  assign rs_arr[0]  = id_rs1;
  assign rs_arr[1]  = id_rs2;
  assign use_arr[0] = id_use_rs1;
  assign use_arr[1] = id_use_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel u_fwd_sel (
        .rs            (rs_arr[gi]),
        .use_rs        (use_arr[gi]),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd           (fwd_arr[gi])
      );
    end
  endgenerate

  assign fwd_a     = fwd_arr[0];
  assign fwd_b     = fwd_arr[1];
  assign pc_target = redirect_pc;

  assign load_use = ex_mem_read &&
                    (rd_hit(ex_reg_write, ex_rd, id_rs1) && id_use_rs1 ||
                     rd_hit(ex_reg_write, ex_rd, id_rs2) && id_use_rs2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_INIT;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pc_sel     = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      ST_INIT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_req) begin
          pc_sel     = 1'b1;
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_next = ST_FLUSH;
        end else if (load_use) begin
          // Stay in RUN: the load moves to MEM next cycle and the hazard clears.
          idex_flush = 1'b1;
        end else if (halt_req) begin
          idex_flush = 1'b1;
          state_next = ST_HALT;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
      end
      ST_FLUSH: begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        state_next = ST_RUN;
      end
      ST_HALT: begin
        idex_flush = 1'b1;
        halted     = 1'b1;
        if (!halt_req) state_next = ST_RUN;
      end
      default: state_next = ST_INIT;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  assign stall_inc = (state_reg == ST_RUN) && !redirect_req && load_use;
  assign flush_inc = (state_reg == ST_RUN) && redirect_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_inc && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_inc && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios, counter saturation
// and randomized traffic against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int M_INIT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;
  localparam int M_HALT  = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic [4:0]      id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic            id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write;
  logic            mem_reg_write, wb_reg_write, redirect_req, halt_req;
  logic [XLEN-1:0] redirect_pc;
  logic            pc_en, ifid_en, ifid_flush, idex_flush, pc_sel, halted;
  logic [XLEN-1:0] pc_target;
  logic [1:0]      fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int m_mode  = M_INIT;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .redirect_req(redirect_req), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pc_sel(pc_sel), .pc_target(pc_target), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int ref_fwd(input logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 1;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2;
    return 0;
  endfunction

  task automatic set_idle();
    {id_rs1, id_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write} = '0;
    {mem_reg_write, wb_reg_write, redirect_req, halt_req} = '0;
    redirect_pc = '0;
  endtask

  // Inputs are set just after a negedge; check outputs, then advance the model at posedge.
  task automatic cycle(input string tag);
    bit hz;
    int nm, ns, nf;
    bit e_pc_en, e_ifid_en, e_iflush, e_xflush, e_pc_sel, e_halted, chk_ifid_en;
    #1;
    if (!rstn) begin
      m_mode = M_INIT; m_stall = 0; m_flush = 0;
    end
    hz = ex_mem_read && ex_reg_write && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    {e_pc_en, e_ifid_en, e_iflush, e_xflush, e_pc_sel, e_halted} = '0;
    chk_ifid_en = 1'b1;
    nm = m_mode; ns = m_stall; nf = m_flush;
    case (m_mode)
      M_INIT: begin e_iflush = 1; e_xflush = 1; nm = M_RUN; end
      M_RUN: begin
        if (redirect_req) begin
          e_pc_sel = 1; e_pc_en = 1; e_iflush = 1; e_xflush = 1; chk_ifid_en = 0;
          nm = M_FLUSH; nf = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
        end else if (hz) begin
          e_xflush = 1; ns = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
        end else if (halt_req) begin
          e_xflush = 1; nm = M_HALT;
        end else begin
          e_pc_en = 1; e_ifid_en = 1;
        end
      end
      M_FLUSH: begin e_pc_en = 1; e_ifid_en = 1; e_iflush = 1; nm = M_RUN; end
      default: begin e_xflush = 1; e_halted = 1; nm = halt_req ? M_HALT : M_RUN; end
    endcase
    if (!rstn) begin nm = M_INIT; ns = 0; nf = 0; end

    $display("cyc %0d %s rstn=%b redir=%b hz=%b halt=%b -> pc_en=%b ifid=%b/%b idex_fl=%b sel=%b halted=%b fwd=%0d/%0d cnt=%0d/%0d",
             cyc, tag, rstn, redirect_req, hz, halt_req, pc_en, ifid_en, ifid_flush,
             idex_flush, pc_sel, halted, fwd_a, fwd_b, stall_cnt, flush_cnt);
    check_val({tag, ".pc_en"}, 64'(pc_en), 64'(e_pc_en));
    if (chk_ifid_en) check_val({tag, ".ifid_en"}, 64'(ifid_en), 64'(e_ifid_en));
    check_val({tag, ".ifid_flush"}, 64'(ifid_flush), 64'(e_iflush));
    check_val({tag, ".idex_flush"}, 64'(idex_flush), 64'(e_xflush));
    check_val({tag, ".pc_sel"}, 64'(pc_sel), 64'(e_pc_sel));
    check_val({tag, ".halted"}, 64'(halted), 64'(e_halted));
    check_val({tag, ".pc_target"}, 64'(pc_target), 64'(redirect_pc));
    if (id_use_rs1) check_val({tag, ".fwd_a"}, 64'(fwd_a), 64'(ref_fwd(id_rs1)));
    if (id_use_rs2) check_val({tag, ".fwd_b"}, 64'(fwd_b), 64'(ref_fwd(id_rs2)));
`ifdef HAZARD_PERF_CNT_EN
    check_val({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    check_val({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`else
    check_val({tag, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
    check_val({tag, ".flush_cnt"}, 64'(flush_cnt), 64'd0);
`endif
    @(posedge clk);
    m_mode = nm; m_stall = ns; m_flush = nf;
    cyc++;
    @(negedge clk);
  endtask

  task automatic load_use_rs1();
    set_idle();
    ex_rd = 5; ex_mem_read = 1; ex_reg_write = 1;
    id_rs1 = 5; id_rs2 = 7; id_use_rs1 = 1; id_use_rs2 = 1;
  endtask

  initial begin
    rstn = 1'b0;
    set_idle();
    @(negedge clk);
    cycle("reset");
    cycle("reset");
    rstn = 1'b1;
    cycle("init");
    cycle("run");

    // lw x5 in EX, add x6,x5,x7 in ID: one stall, then forward from MEM.
    load_use_rs1();
    cycle("lduse");
    set_idle();
    mem_rd = 5; mem_reg_write = 1;
    id_rs1 = 5; id_rs2 = 7; id_use_rs1 = 1; id_use_rs2 = 1;
    cycle("lduse_fwd");

    set_idle(); redirect_req = 1; redirect_pc = 32'h40;
    cycle("redir");
    redirect_req = 0;
    cycle("redir_flush");
    cycle("redir_run");

    load_use_rs1(); redirect_req = 1; redirect_pc = 32'h80;
    cycle("redir_vs_lduse");
    set_idle();
    cycle("redir_vs_lduse_flush");

    set_idle(); mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
    id_rs2 = 3; id_use_rs2 = 1; id_rs1 = 3; id_use_rs1 = 1;
    cycle("fwd_mem_wins");
    mem_rd = 0; wb_rd = 0; id_rs1 = 0; id_rs2 = 0;
    cycle("fwd_x0");
    mem_reg_write = 0; wb_rd = 9; id_rs1 = 9;
    cycle("fwd_wb");

    set_idle(); halt_req = 1;
    for (int i = 0; i < 5; i++) cycle("halt_on");
    halt_req = 0;
    cycle("halt_release");
    cycle("after_halt");

    halt_req = 1;
    cycle("halt2_enter");
    redirect_req = 1; redirect_pc = 32'h1234;
    cycle("halt2_redir_ignored");
    redirect_req = 0;
    rstn = 1'b0;
    cycle("halt2_reset");
    rstn = 1'b1; halt_req = 0;
    cycle("halt2_init");
    cycle("halt2_run");

    // Held load-use and held redirect drive both counters to saturation.
    load_use_rs1();
    for (int i = 0; i < 20; i++) cycle("stall_sat");
    set_idle(); redirect_req = 1; redirect_pc = 32'hC0;
    for (int i = 0; i < 40; i++) cycle("flush_sat");

    set_idle();
    for (int i = 0; i < 400; i++) begin
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      {id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write} = 6'($urandom);
      redirect_req = ($urandom_range(0, 4) == 0);
      redirect_pc  = $urandom;
      if ($urandom_range(0, 3) == 0) halt_req = ~halt_req;
      rstn = ($urandom_range(0, 149) != 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
